cnn: RTL and testbench

Streaming 2×2 convolution engine for the CNN processor datapath. It loads a 2×2 kernel and a 3×3 input feature map over 8-bit byte-serial ports. It computes the four stride-1, no-padding output pixels and presents them one per cycle on a 19-bit result bus. It sits between the feature-map/filter byte feeders and the downstream accumulation or pooling stage.

---
 rtl/cnn.sv | 60 ++++++
 tb/tb_cnn.sv | 121 ++++++++++++
 2 files changed

// File: rtl/cnn.sv
// cnn: streaming 2x2 convolution over a byte-serial 3x3 feature map; define CNN_SIGNED_EN for two's-complement operands
module cnn (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [7:0]  filtermap,
  input  logic [7:0]  inputFmap,
  output logic [18:0] convolution = '0,
  output logic        conv_valid = 1'b0
);
  typedef enum logic {LOAD, COMPUTE} state_t;
`ifdef CNN_SIGNED_EN
  typedef logic signed [15:0] prod_t;
  typedef logic signed [7:0]  op_t;
`else
  typedef logic [15:0] prod_t;
  typedef logic [7:0]  op_t;
`endif
  state_t      state = LOAD, state_n;
  logic [3:0]  cnt = '0, cnt_n, base;
  logic        last;
  logic [7:0]  x [9] = '{default: '0};
  logic [7:0]  k [4] = '{default: '0};
  prod_t       prod [4];
  logic [18:0] pix;
  always_ff @(posedge clock)
    if (reset) begin
      state <= LOAD;
      cnt <= '0;
    end else if (enable) begin
      state <= state_n;
      cnt <= cnt_n;
    end
  always_comb begin
    last = state == LOAD ? cnt == 4'd8 : cnt == 4'd3;
    state_n = last ? (state == LOAD ? COMPUTE : LOAD) : state;
    cnt_n = last ? '0 : cnt + 4'd1;
  end
  // window origin 3r+c for pixel p = {r,c}
  always_comb begin
    base = cnt[1] ? (cnt[0] ? 4'd4 : 4'd3) : (cnt[0] ? 4'd1 : 4'd0);
    prod[0] = prod_t'(op_t'(k[0])) * prod_t'(op_t'(x[base]));
    prod[1] = prod_t'(op_t'(k[1])) * prod_t'(op_t'(x[base + 4'd1]));
    prod[2] = prod_t'(op_t'(k[2])) * prod_t'(op_t'(x[base + 4'd3]));
    prod[3] = prod_t'(op_t'(k[3])) * prod_t'(op_t'(x[base + 4'd4]));
    pix = 19'(prod[0]) + 19'(prod[1]) + 19'(prod[2]) + 19'(prod[3]);
  end
  always_ff @(posedge clock)
    if (reset) begin
      for (int i = 0; i < 9; i++) x[i] <= '0;
      for (int i = 0; i < 4; i++) k[i] <= '0;
      convolution <= '0;
      conv_valid <= 1'b0;
    end else if (enable) begin
      if (state == LOAD) x[cnt] <= inputFmap;
      if (state == LOAD && cnt < 4'd4) k[cnt[1:0]] <= filtermap;
      if (state == COMPUTE) convolution <= pix;
      conv_valid <= state == COMPUTE;
    end
endmodule

// File: tb/tb_cnn.sv
// tb_cnn: randomized and directed frames checked against a pixel-level model of the 2x2 convolution
module tb_cnn;
  logic        clock = 1'b0, reset = 1'b0, enable = 1'b0;
  logic [7:0]  filtermap = '0, inputFmap = '0;
  logic [18:0] convolution;
  logic        conv_valid;
  int          checks = 0, errors = 0, ph = 0;
  logic [7:0]  mk [4] = '{default: '0};
  logic [7:0]  mx [9] = '{default: '0};
  logic [18:0] ec = '0;
  logic        ev = 1'b0;
  logic [18:0] got [$];

  cnn dut (.clock(clock), .reset(reset), .enable(enable), .filtermap(filtermap),
           .inputFmap(inputFmap), .convolution(convolution), .conv_valid(conv_valid));

  always #5 clock = ~clock;

  function automatic int sv(input logic [7:0] b);
`ifdef CNN_SIGNED_EN
    return int'($signed(b));
`else
    return int'(b);
`endif
  endfunction

  function automatic int pixel(input int p);
    int s = 0;
    for (int dr = 0; dr < 2; dr++)
      for (int dc = 0; dc < 2; dc++)
        s += sv(mk[2*dr+dc]) * sv(mx[3*(p/2+dr) + p%2 + dc]);
    return s;
  endfunction

  task automatic step(input logic en, input logic rs, input logic [7:0] f, input logic [7:0] i);
    enable = en; reset = rs; filtermap = f; inputFmap = i;
    @(posedge clock); #1;
    if (rs) begin
      ph = 0; ec = '0; ev = 1'b0;
      for (int n = 0; n < 4; n++) mk[n] = '0;
      for (int n = 0; n < 9; n++) mx[n] = '0;
    end else if (en) begin
      if (ph < 9) begin
        mx[ph] = i;
        if (ph < 4) mk[ph] = f;
        ev = 1'b0;
      end else begin
        ec = 19'(pixel(ph - 9));
        ev = 1'b1;
      end
      ph = (ph + 1) % 13;
    end
    checks += 2;
    assert (convolution === ec) else begin errors++; $error("FAIL conv: got %0d expected %0d", convolution, ec); end
    assert (conv_valid === ev) else begin errors++; $error("FAIL valid: got %b expected %b", conv_valid, ev); end
    if (en && !rs && conv_valid) got.push_back(convolution);
  endtask

  task automatic frame(input logic [7:0] k [4], input logic [7:0] x [9], input int stall, input int len);
    for (int n = 0; n < len; n++) begin
      if (n == stall) repeat (3) step(1'b0, 1'b0, 8'($urandom), 8'($urandom));
      step(1'b1, 1'b0, n < 4 ? k[n % 4] : 8'($urandom), n < 9 ? x[n % 9] : 8'($urandom));
    end
  endtask

  task automatic check_seq(input logic [18:0] e [4]);
    checks++;
    assert (got.size() == 4) else begin errors++; $error("FAIL pixel_count: got %0d expected 4", got.size()); end
    for (int n = 0; n < 4; n++)
      if (n < got.size()) begin
        checks++;
        assert (got[n] === e[n]) else begin errors++; $error("FAIL pixel%0d: got %0d expected %0d", n, got[n], e[n]); end
      end
    got.delete();
  endtask

  initial begin
    logic [7:0]  kb [4] = '{8'd1, 8'd2, 8'd3, 8'd4};
    logic [7:0]  xb [9] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    logic [7:0]  k2 [4] = '{8'd1, 8'd0, 8'd0, 8'd1};
    logic [7:0]  x2 [9] = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    logic [7:0]  km [4] = '{default: 8'hff};
    logic [7:0]  xm [9] = '{default: 8'hff};
    logic [7:0]  kr [4];
    logic [7:0]  xr [9];
    logic [18:0] eb [4] = '{19'd37, 19'd47, 19'd67, 19'd77};
    logic [18:0] e2 [4] = '{19'd14, 19'd12, 19'd8, 19'd6};
`ifdef CNN_SIGNED_EN
    logic [18:0] em [4] = '{default: 19'd4};
`else
    logic [18:0] em [4] = '{default: 19'd260100};
`endif
    #1;
    checks += 2;
    assert (convolution === 19'd0) else begin errors++; $error("FAIL powerup_conv: got %0d expected 0", convolution); end
    assert (conv_valid === 1'b0) else begin errors++; $error("FAIL powerup_valid: got %b expected 0", conv_valid); end
    frame(kb, xb, -1, 13);
    check_seq(eb);
    frame(k2, x2, -1, 13);
    check_seq(e2);
    step(1'b1, 1'b1, 8'($urandom), 8'($urandom));
    frame(km, xm, -1, 13);
    check_seq(em);
    frame(kb, xb, 5, 13);
    check_seq(eb);
    frame(kb, xb, -1, 11);
    got.delete();
    step(1'b1, 1'b1, 8'($urandom), 8'($urandom));
    frame(kb, xb, -1, 13);
    check_seq(eb);
    repeat (8) begin
      for (int n = 0; n < 4; n++) kr[n] = 8'($urandom);
      for (int n = 0; n < 9; n++) xr[n] = 8'($urandom);
      frame(kr, xr, int'($urandom_range(0, 13)), 13);
      got.delete();
    end
    repeat (40) step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0), 8'($urandom), 8'($urandom));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
